// File: rtl/servant_loader_pkg.sv
// Shared state encodings and small helpers for the UART image loader.
package servant_loader_pkg;

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_RX,
        L_DRAIN
    } ld_state_t;

    function automatic logic [3:0] lane_bit(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/servant_uart_loader_if.sv
// Wishbone write-master bundle driven by the loader.
interface servant_uart_loader_if #(
    parameter int aw = 8
);
    logic [aw-1:2] adr;
    logic [31:0]   dat;
    logic [3:0]    sel;
    logic          we;
    logic          cyc;
    logic          ack;

    modport master (output adr, dat, sel, we, cyc, input ack);
    modport slave  (input adr, dat, sel, we, cyc, output ack);
endinterface

// File: rtl/servant_uart_rx.sv
// 8N1 serial receiver: synchronised input, mid-bit sampling, byte and framing-error pulses.
module servant_uart_rx
    import servant_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err,
    output logic       o_idle
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic meta_q, sync_q, prev_q;

    rx_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= i_rx;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            R_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (prev_q && !sync_q) state_d = R_START;
            end
            R_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = sync_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        state_d = R_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = R_WAIT_HIGH;
                    end
                end
            end
            R_WAIT_HIGH: begin
                cnt_d = '0;
                if (sync_q) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign o_data      = shift_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_idle      = (state_q == R_IDLE);

endmodule

// File: rtl/servant_uart_loader.sv
// Receives a byte stream over UART and writes it little-endian into RAM over Wishbone.
module servant_uart_loader
    import servant_loader_pkg::*;
#(
    parameter int depth        = 256,
    parameter int aw           = $clog2(depth),
    parameter int CLKS_PER_BIT = 868,
    parameter int IDLE_BITS    = 20
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic          i_uart_rx,
    output logic [aw-1:2] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic          i_wb_ack,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int AWW = aw - 2;
    localparam int unsigned IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
    localparam int unsigned IW = $clog2(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [aw-1:2] ADR_LAST  = AWW'(depth / 4 - 1);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_ferr, rx_idle;

    servant_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk      (i_wb_clk),
        .i_rst      (i_wb_rst),
        .i_rx       (i_uart_rx),
        .o_data     (rx_byte),
        .o_valid    (rx_valid),
        .o_frame_err(rx_ferr),
        .o_idle     (rx_idle)
    );

    ld_state_t     state_q, state_d;
    logic [31:0]   buf_q, buf_d;
    logic [3:0]    lanes_q, lanes_d;
    logic [1:0]    idx_q, idx_d;
    logic [aw-1:2] word_adr_q, word_adr_d;
    logic [aw-1:2] adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          cyc_q, cyc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q    <= L_IDLE;
            buf_q      <= '0;
            lanes_q    <= '0;
            idx_q      <= '0;
            word_adr_q <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            cyc_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            lanes_q    <= lanes_d;
            idx_q      <= idx_d;
            word_adr_q <= word_adr_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            cyc_q      <= cyc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    logic ack_ok;
    logic idle_tick;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        lanes_d    = lanes_q;
        idx_d      = idx_q;
        word_adr_d = word_adr_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        cyc_d      = cyc_q;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q || rx_ferr;
        idle_cnt_d = '0;
        ack_ok     = cyc_q && i_wb_ack;
        idle_tick  = rx_idle && !cyc_q && !rx_valid;

        if (ack_ok) begin
            cyc_d      = 1'b0;
            adr_d      = '0;
            dat_d      = '0;
            sel_d      = '0;
            word_adr_d = (word_adr_q == ADR_LAST) ? '0 : word_adr_q + 1'b1;
        end

        if (rx_valid && state_q != L_DRAIN) begin
            if (state_q == L_IDLE) begin
                state_d    = L_RX;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                word_adr_d = '0;
            end
            // A lane still holding an unwritten byte means the writer fell behind.
            if (lanes_q[idx_q]) begin
                err_d = 1'b1;
            end else begin
                buf_d[{idx_q, 3'b000} +: 8] = rx_byte;
                lanes_d = lanes_q | lane_bit(idx_q);
                idx_d   = idx_q + 1'b1;
            end
        end

        if (lanes_d == 4'hF && !cyc_q) begin
            cyc_d   = 1'b1;
            adr_d   = word_adr_d;
            dat_d   = buf_d;
            sel_d   = 4'hF;
            buf_d   = '0;
            lanes_d = '0;
        end

        case (state_q)
            L_RX: begin
                if (idle_tick) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d = L_DRAIN;
                        if (lanes_q != 4'h0) begin
                            cyc_d = 1'b1;
                            adr_d = word_adr_q;
                            dat_d = buf_q;
                            sel_d = lanes_q;
                        end
                        buf_d   = '0;
                        lanes_d = '0;
                        idx_d   = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            L_DRAIN: begin
                if (!cyc_q || ack_ok) begin
                    state_d = L_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_cyc = cyc_q;
    assign o_wb_we  = cyc_q;
    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_servant_uart_loader.sv
// Randomised image loads checked against a byte-list model of the expected RAM writes.
module tb_servant_uart_loader;

    localparam int CPB       = 4;
    localparam int IDLE_BITS = 20;
    localparam int DEPTH     = 16;
    localparam int AW        = $clog2(DEPTH);
    localparam int WORDS     = DEPTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic busy, done, err;

    servant_uart_loader_if #(.aw(AW)) wb ();

    always #5 clk = ~clk;

    servant_uart_loader #(
        .depth       (DEPTH),
        .aw          (AW),
        .CLKS_PER_BIT(CPB),
        .IDLE_BITS   (IDLE_BITS)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_uart_rx(rx),
        .o_wb_adr (wb.adr),
        .o_wb_dat (wb.dat),
        .o_wb_sel (wb.sel),
        .o_wb_we  (wb.we),
        .o_wb_cyc (wb.cyc),
        .i_wb_ack (wb.ack),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int zero_viol = 0;
    int we_viol = 0;
    int unsigned obs_adr[$];
    int unsigned obs_dat[$];
    int unsigned obs_sel[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave: ack one cycle after cyc, log each write, watch idle-bus zeroing.
    initial begin
        wb.ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                wb.ack = 1'b0;
            end else if (wb.cyc && !wb.ack) begin
                wb.ack = 1'b1;
                obs_adr.push_back(int'(wb.adr));
                obs_dat.push_back(wb.dat);
                obs_sel.push_back(int'(wb.sel));
                if (!wb.we) we_viol++;
            end else begin
                wb.ack = 1'b0;
            end
            if (!wb.cyc && (wb.adr != 0 || wb.dat != 0 || wb.sel != 0 || wb.we)) zero_viol++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"},  wb.cyc, 0);
        check({tag, "_we"},   wb.we,  0);
        check({tag, "_adr"},  wb.adr, 0);
        check({tag, "_dat"},  wb.dat, 0);
        check({tag, "_sel"},  wb.sel, 0);
        check({tag, "_busy"}, busy,   0);
        check({tag, "_done"}, done,   0);
        check({tag, "_err"},  err,    0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    // Expected writes: byte n goes to lane n%4 of word n/4, addresses wrap over WORDS.
    task automatic run_image(input logic [7:0] bytes[$], input string tag);
        int n, nw, m;
        logic [31:0] d;
        logic [3:0] s;
        n  = bytes.size();
        nw = (n + 3) / 4;
        obs_adr.delete();
        obs_dat.delete();
        obs_sel.delete();
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[i], 1'b1);
            if (i == 0) begin
                repeat (2) @(posedge clk);
                #1;
                check({tag, "_busy_start"}, busy, 1);
                check({tag, "_done_clr"}, done, 0);
            end
            repeat ($urandom_range(0, 12)) @(posedge clk);
        end
        wait_done(tag);
        check({tag, "_nwrites"}, obs_adr.size(), nw);
        m = (obs_adr.size() < nw) ? obs_adr.size() : nw;
        for (int w = 0; w < m; w++) begin
            d = '0;
            s = '0;
            for (int l = 0; l < 4; l++) begin
                if (4 * w + l < n) begin
                    d[8*l +: 8] = bytes[4*w + l];
                    s[l] = 1'b1;
                end
            end
            check($sformatf("%s_w%0d_adr", tag, w), obs_adr[w], w % WORDS);
            check($sformatf("%s_w%0d_dat", tag, w), obs_dat[w], d);
            check($sformatf("%s_w%0d_sel", tag, w), obs_sel[w], s);
        end
    endtask

    task automatic rand_bytes(input int n, output logic [7:0] q[$]);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        logic [7:0] img[$];
        logic [7:0] b;

        do_reset();
        check_all_zero("reset");

        img = {8'h78, 8'h56, 8'h34, 8'h12};
        run_image(img, "word4");

        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_image(img, "partial6");

        obs_adr.delete();
        send_byte(8'hA5, 1'b0);
        repeat (120) @(posedge clk);
        #1;
        check("ferr_nwrites", obs_adr.size(), 0);
        check("ferr_err", err, 1);
        check("ferr_busy", busy, 0);
        check("ferr_done_held", done, 1);
        rand_bytes($urandom_range(1, 9), img);
        run_image(img, "after_ferr");
        check("after_ferr_err_sticky", err, 1);

        do_reset();
        obs_adr.delete();
        @(posedge clk);
        #1;
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("glitch_busy", busy, 0);
        check("glitch_nwrites", obs_adr.size(), 0);
        check("glitch_err", err, 0);

        rand_bytes(20, img);
        run_image(img, "wrap20");

        for (int t = 0; t < 3; t++) begin
            rand_bytes($urandom_range(1, 13), img);
            run_image(img, $sformatf("rand%0d", t));
        end

        rand_bytes(5, img);
        for (int i = 0; i < 5; i++) send_byte(img[i], 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_busy_before", busy, 1);
        b = 8'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        drive_bit(b[0]);
        drive_bit(b[1]);
        rx = b[2];
        @(posedge clk);
        #1;
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrst");
        rst = 1'b0;
        repeat (20) @(posedge clk);
        rand_bytes(6, img);
        run_image(img, "post_rst");

        check("idle_bus_zero", zero_viol, 0);
        check("we_with_cyc", we_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
